// File: rtl/reg_write_initiator.sv
// Write-side bus initiator for the register file: queues host write requests
// in a small FIFO and drains them one per cycle while io_enable is high.
module reg_write_initiator #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_req_valid,
    output logic                         io_req_ready,
    input  logic [ADDR_WIDTH-1:0]        io_req_addr,
    input  logic [DATA_WIDTH-1:0]        io_req_data,
    input  logic                         io_enable,
    output logic                         io_mem_wr,
    output logic [ADDR_WIDTH-1:0]        io_mem_addr,
    output logic [DATA_WIDTH-1:0]        io_mem_din,
    output logic [$clog2(DEPTH):0]       io_count,
    output logic                         io_busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // Ready comes from registered occupancy only, so a pop never opens a slot
    // for a push in the same cycle while the FIFO is full.
    assign io_req_ready = (count != CNT_W'(DEPTH));
    assign push         = io_req_valid && io_req_ready;
    assign pop          = io_enable && (count != '0);
    assign io_count     = count;
    assign io_busy      = (count != '0) || io_mem_wr;

    // Storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= {io_req_addr, io_req_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            io_mem_wr   <= 1'b0;
            io_mem_addr <= '0;
            io_mem_din  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // Address and data hold between strobes so the selected register
            // never changes without a write.
            if (pop) begin
                {io_mem_addr, io_mem_din} <= fifo_mem[rd_ptr];
                rd_ptr                    <= rd_ptr + PTR_W'(1);
            end
            io_mem_wr <= pop;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_initiator.sv
// Self-checking bench for reg_write_initiator: scoreboard queue of expected
// writes plus per-scenario timing and status checks.
module tb_reg_write_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [1:0]  io_req_addr;
    logic [15:0] io_req_data;
    logic        io_enable;
    logic        io_mem_wr;
    logic [1:0]  io_mem_addr;
    logic [15:0] io_mem_din;
    logic [2:0]  io_count;
    logic        io_busy;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int max_cnt = 0;
    logic [17:0] sb [$];

    reg_write_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(16), .DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_addr  (io_req_addr),
        .io_req_data  (io_req_data),
        .io_enable    (io_enable),
        .io_mem_wr    (io_mem_wr),
        .io_mem_addr  (io_mem_addr),
        .io_mem_din   (io_mem_din),
        .io_count     (io_count),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;

    // Every strobe must match the oldest outstanding request.
    always @(negedge clock) begin
        if (int'(io_count) > max_cnt) max_cnt = int'(io_count);
        if (reset && io_mem_wr) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write got addr=%0d din=%h, required no write", io_mem_addr, io_mem_din);
            end else begin
                logic [17:0] exp;
                exp = sb.pop_front();
                if ({io_mem_addr, io_mem_din} !== exp) begin
                    errors++;
                    $display("FAIL sb_write_data got addr=%0d din=%h, required addr=%0d din=%h",
                             io_mem_addr, io_mem_din, exp[17:16], exp[15:0]);
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic do_push(input logic [1:0] a, input logic [15:0] d);
        int n = 0;
        while (!io_req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!io_req_ready) begin
            errors++;
            $display("FAIL push_timeout got ready=0 for 50 cycles, required ready=1");
        end else begin
            io_req_valid = 1'b1;
            io_req_addr  = a;
            io_req_data  = d;
            sb.push_back({a, d});
            @(negedge clock);
            io_req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || io_busy) && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0 || io_busy) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending busy=%0b, required 0 pending busy=0", sb.size(), io_busy);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        io_req_valid = 1'b1;
        io_req_addr  = 2'd3;
        io_req_data  = 16'hFFFF;
        io_enable    = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({io_mem_wr, io_mem_addr, io_mem_din, io_count, io_req_ready} !== {1'b0, 2'd0, 16'h0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got wr=%0b addr=%0d din=%h count=%0d ready=%0b, required 0 0 0000 0 1",
                     io_mem_wr, io_mem_addr, io_mem_din, io_count, io_req_ready);
        end
        reset        = 1'b1;
        io_req_valid = 1'b0;
        io_enable    = 1'b0;
        @(negedge clock);
        checks++;
        if (io_count !== 3'd0 || io_req_ready !== 1'b1 || io_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got count=%0d ready=%0b busy=%0b, required 0 1 0", io_count, io_req_ready, io_busy);
        end
    endtask

    task automatic test_single();
        io_enable = 1'b1;
        do_push(2'd1, 16'hBEEF);
        checks++;
        if (io_mem_wr !== 1'b0 || io_count !== 3'd1) begin
            errors++;
            $display("FAIL single_t1 got wr=%0b count=%0d, required wr=0 count=1", io_mem_wr, io_count);
        end
        @(negedge clock);
        checks++;
        if ({io_mem_wr, io_mem_addr, io_mem_din} !== {1'b1, 2'd1, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_t2 got wr=%0b addr=%0d din=%h, required 1 1 beef", io_mem_wr, io_mem_addr, io_mem_din);
        end
        @(negedge clock);
        checks++;
        if (io_mem_wr !== 1'b0 || io_mem_din !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_t3 got wr=%0b din=%h, required wr=0 din=beef", io_mem_wr, io_mem_din);
        end
        io_enable = 1'b0;
    endtask

    task automatic test_fill_and_drain();
        io_enable = 1'b0;
        for (int i = 0; i < 4; i++) do_push(2'(i), 16'h1111 * 16'(i + 1));
        checks++;
        if (io_count !== 3'd4 || io_req_ready !== 1'b0 || io_mem_wr !== 1'b0 || io_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got count=%0d ready=%0b wr=%0b busy=%0b, required 4 0 0 1",
                     io_count, io_req_ready, io_mem_wr, io_busy);
        end
        io_req_valid = 1'b1;
        io_req_addr  = 2'd0;
        io_req_data  = 16'h5555;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (io_count !== 3'd4 || io_req_ready !== 1'b0 || io_mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL fill_stall got count=%0d ready=%0b wr=%0b, required 4 0 0", io_count, io_req_ready, io_mem_wr);
            end
        end
        io_req_valid = 1'b0;
        io_enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (io_mem_wr !== 1'b1 || io_mem_din !== 16'h1111 * 16'(i + 1) || io_busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_beat%0d got wr=%0b din=%h busy=%0b, required 1 %h 1",
                         i, io_mem_wr, io_mem_din, io_busy, 16'h1111 * 16'(i + 1));
            end
        end
        @(negedge clock);
        checks++;
        if (io_mem_wr !== 1'b0 || io_busy !== 1'b0 || io_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_end got wr=%0b busy=%0b count=%0d, required 0 0 0", io_mem_wr, io_busy, io_count);
        end
        io_enable = 1'b0;
    endtask

    task automatic test_gated_drain();
        int w0;
        io_enable = 1'b0;
        for (int i = 0; i < 4; i++) do_push(2'(3 - i), 16'hA000 + 16'(i));
        w0 = wr_seen;
        io_enable = 1'b1;
        repeat (2) @(negedge clock);
        io_enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (io_mem_wr !== 1'b0 || io_mem_addr !== 2'd2 || io_mem_din !== 16'hA001 || io_count !== 3'd2) begin
                errors++;
                $display("FAIL gated_pause got wr=%0b addr=%0d din=%h count=%0d, required 0 2 a001 2",
                         io_mem_wr, io_mem_addr, io_mem_din, io_count);
            end
        end
        checks++;
        if (wr_seen - w0 != 2) begin
            errors++;
            $display("FAIL gated_first_window got %0d writes, required 2", wr_seen - w0);
        end
        io_enable = 1'b1;
        wait_drain();
        checks++;
        if (wr_seen - w0 != 4 || io_mem_din !== 16'hA003) begin
            errors++;
            $display("FAIL gated_total got %0d writes din=%h, required 4 a003", wr_seen - w0, io_mem_din);
        end
        io_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w0;
        w0        = wr_seen;
        max_cnt   = 0;
        io_enable = 1'b1;
        for (int i = 0; i < 10; i++) do_push(2'(i % 4), 16'h6000 + 16'(i));
        wait_drain();
        checks++;
        if (wr_seen - w0 != 10 || max_cnt > 1) begin
            errors++;
            $display("FAIL stream got %0d writes max_count=%0d, required 10 writes max_count<=1", wr_seen - w0, max_cnt);
        end
        io_enable = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        io_enable = 1'b0;
        for (int i = 0; i < 3; i++) do_push(2'(i), 16'h7000 + 16'(i));
        io_enable = 1'b1;
        @(negedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        checks++;
        if (io_mem_wr !== 1'b0 || io_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid got wr=%0b count=%0d, required 0 0", io_mem_wr, io_count);
        end
        reset = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (io_count !== 3'd0 || io_busy !== 1'b0 || io_mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got count=%0d busy=%0b wr=%0b, required 0 0 0", io_count, io_busy, io_mem_wr);
        end
        io_enable = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        io_req_valid = 1'b0;
        io_req_addr  = '0;
        io_req_data  = '0;
        io_enable    = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_fill_and_drain();
        test_gated_drain();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
